// File: rtl/cb_config_chain.sv
// Connection-box tile with a serially loaded, parity-checked configuration frame.
// A shadow chain collects the frame; a commit validates it and copies it into the active routing register.
module cb_config_chain #(
  parameter int CHAN_W = 4,
  parameter int CLB_IN = 4
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              prog_en,
  input  logic              prog_in,
  input  logic              prog_commit,
  output logic              prog_out,
  output logic              cfg_valid,
  output logic              cfg_err,
  output logic              cfg_busy,
  input  logic [CHAN_W-1:0] chan_in,
  input  logic [CHAN_W-1:0] side_in,
  input  logic              clb_out,
  output logic [CHAN_W-1:0] chan_out,
  output logic [CHAN_W-1:0] side_out,
  output logic [CLB_IN-1:0] clb_in
);

  localparam int SEL_W   = $clog2(2 * CHAN_W);
  localparam int CFG_LEN = CLB_IN * SEL_W + 2 * CHAN_W;
  localparam int FRAME   = CFG_LEN + 1;
  localparam int CNT_W   = $clog2(FRAME + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, ERR} state_t;

  state_t             state_reg, state_next;
  logic [FRAME-1:0]   shadow_reg, shadow_next;
  logic [CFG_LEN-1:0] active_reg, active_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               valid_reg, valid_next;
  logic               err_reg, err_next;
  logic [FRAME-1:0]   shifted;

  assign shifted = {prog_in, shadow_reg[FRAME-1:1]};

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_reg  <= IDLE;
      shadow_reg <= '0;
      active_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      shadow_reg <= shadow_next;
      active_reg <= active_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    shadow_next = shadow_reg;
    active_next = active_reg;
    count_next  = count_reg;
    valid_next  = valid_reg;
    err_next    = err_reg;
    unique case (state_reg)
      IDLE: begin
        if (prog_commit) begin
          state_next = CHECK;
        end else if (prog_en) begin
          shadow_next = shifted;
          count_next  = CNT_W'(1);
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        // Commit wins over a same-cycle shift, so that bit is dropped.
        if (prog_commit) begin
          state_next = CHECK;
        end else if (prog_en) begin
          shadow_next = shifted;
          if (count_reg != CNT_SAT) count_next = count_reg + CNT_W'(1);
        end
      end
      CHECK: begin
        if ((count_reg == CNT_FULL) && ((^shadow_reg) == 1'b0)) begin
          active_next = shadow_reg[FRAME-1:1];
          valid_next  = 1'b1;
          err_next    = 1'b0;
          count_next  = '0;
          state_next  = IDLE;
        end else begin
          err_next   = 1'b1;
          state_next = ERR;
        end
      end
      ERR: begin
        if (prog_en) begin
          shadow_next = shifted;
          count_next  = CNT_W'(1);
          state_next  = SHIFT;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign prog_out  = shadow_reg[0];
  assign cfg_valid = valid_reg;
  assign cfg_err   = err_reg;
  assign cfg_busy  = (state_reg != IDLE);

  // Source vector: odd entries come from the channel side, even from the opposite side.
  logic [2*CHAN_W-1:0] src;

  genvar gi;
  generate
    for (gi = 0; gi < CHAN_W; gi++) begin : g_chan
      assign src[2*gi+1]  = chan_in[gi];
      assign src[2*gi]    = side_in[gi];
      assign chan_out[gi] = valid_reg & (active_reg[2*gi+1] ? clb_out : side_in[gi]);
      assign side_out[gi] = valid_reg & (active_reg[2*gi]   ? clb_out : chan_in[gi]);
    end
    for (gi = 0; gi < CLB_IN; gi++) begin : g_clb
      logic [SEL_W-1:0] sel;
      assign sel        = active_reg[2*CHAN_W + (gi+1)*SEL_W - 1 -: SEL_W];
      assign clb_in[gi] = valid_reg & src[sel];
    end
  endgenerate

endmodule
